mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory stage, directly downstream of the EX/MEM pipeline register.
- Consumes execute_data_t and performs loads/stores over the 64-bit data bus (dbus request/response handshake).
- Produces memory_data_t for the MEM/WB register.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 64, data/address width.
- BUS_BYTES, 8, bus width in bytes; strobe width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- dataE  in  execute_data_t  EX/MEM register contents: valid, mem_read, mem_write, msize, mem_unsigned, addr[63:0], wdata[63:0], rd, result, pc
- flush  in  1  squash current instruction (from hazard/exception unit)
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  bus address
- dreq_size  out  msize_t  access size (MSIZE1/2/4/8)
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  64  lane-aligned write data
- dresp_addr_ok  in  1  address accepted (informational)
- dresp_data_ok  in  1  transaction complete
- dresp_data  in  64  raw read data, lane-aligned
- dataM_next  out  memory_data_t  to MEM/WB: valid, rd, wb_data, pc, plus misalign flag when the optional feature is enabled
- stall_out  out  1  hold EX/MEM and earlier stages

Behaviour:
- Reset value of every output and register is 0; FSM resets to IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op (valid=0, or neither mem_read nor mem_write):
  - dataM_next passes through combinationally, 0-cycle latency.
  - wb_data = result; stall_out=0; dreq_valid=0.
- IDLE, memory op and flush=0:
  - Drive dreq_valid=1 combinationally; stall_out=1.
  - If dresp_data_ok is already high this cycle: capture data, go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - dreq_valid=1; addr, size, strobe and data held stable from dataE (EX/MEM is stalled).
  - stall_out=1; dataM_next.valid=0.
  - On dresp_data_ok: latch extended load data into an internal register, go to DONE.
- DONE:
  - dreq_valid=0; stall_out=0.
  - dataM_next.valid=1 (0 if squashed); wb_data = latched value for loads, result for stores.
  - Always returns to IDLE next cycle. The same dataE is still visible this cycle and must not be reissued.
- Store encoding:
  - strobe = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - dreq_data = wdata << (8*addr[2:0]).
- Load encoding:
  - Shift dresp_data right by 8*addr[2:0], truncate to size.
  - Sign-extend, or zero-extend when mem_unsigned=1.
- flush:
  - In IDLE: no request is issued; dataM_next.valid=0.
  - In WAIT: the bus transaction cannot be aborted. Keep dreq_valid until data_ok, set an internal squash bit, and emit valid=0 in DONE.
  - squash bit clears on leaving DONE.
- Reset mid-transaction: async return to IDLE with dreq_valid=0 immediately. The bus side is reset by the same reset.
- dresp_data_ok in IDLE with no request pending is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Enabled:
  - A memory op whose addr is not aligned to its size (addr[1:0]!=0 for size 4, etc.) issues no bus request and causes no stall.
  - dataM_next.valid=1 with the misalign flag set and wb_data=addr, for the exception unit.
- Disabled:
  - No check; the access is issued as-is. The strobe shift may run past byte 7, and the excess bits are dropped.
  - The misalign field is absent.

Decomposition:
- pipes package: execute_data_t, memory_data_t, msize_t, mem_state_t enum (IDLE/WAIT/DONE).
- common package: XLEN, BUS_BYTES.
- One sub-module, mem_lane_align: purely combinational strobe/data shifting and load extraction/extension, shared by both paths.

Test Plan:
- ALU op (valid=1, mem_read=mem_write=0, result=0x1234) -> same cycle: dataM_next.valid=1, wb_data=0x1234, stall_out=0, dreq_valid=0.
- LB addr=0x1003, dresp_data=0x00000000_80000000 after 3 WAIT cycles -> stall_out high 4 cycles; DONE wb_data=0xFFFF_FFFF_FFFF_FF80; LBU variant gives 0x80.
- SH addr=0x2006, wdata=0xBEEF -> dreq_strobe=0xC0, dreq_data=0xBEEF_0000_0000_0000, dreq_size=MSIZE2; held stable until data_ok.
- LD with data_ok in the issue cycle -> DONE the next cycle with wb_data=dresp_data; no second request while the same dataE is still present.
- flush asserted in WAIT -> dreq_valid stays 1 until data_ok; DONE emits valid=0; next op issues normally.
- reset driven to 0 during WAIT -> dreq_valid=0 and state IDLE without a clock edge; with MEM_MISALIGN_CHECK_EN, LW addr=0x1002 -> no request, misalign=1, wb_data=0x1002.

Source files
------------

// File: rtl/common.sv
// Shared machine-wide constants for the datapath.
package common;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned BUS_BYTES = 8;

endpackage

// File: rtl/pipes.sv
// Pipeline register payloads and memory-stage types.
// Optional field: misalign in memory_data_t, present only with MEM_MISALIGN_CHECK_EN.
package pipes;

  import common::*;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic            valid;
    logic            mem_read;
    logic            mem_write;
    msize_t          msize;
    logic            mem_unsigned;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc;
  } execute_data_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] pc;
`ifdef MEM_MISALIGN_CHECK_EN
    logic            misalign;
`endif
  } memory_data_t;

  // Byte-enable pattern of an access before it is moved into its lane.
  function automatic logic [BUS_BYTES-1:0] size_mask(msize_t size);
    logic [BUS_BYTES-1:0] mask;
    case (size)
      MSIZE1:  mask = 8'h01;
      MSIZE2:  mask = 8'h03;
      MSIZE4:  mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(msize_t size, logic [2:0] offset);
    logic [2:0] low_bits;
    case (size)
      MSIZE1:  low_bits = 3'b000;
      MSIZE2:  low_bits = 3'b001;
      MSIZE4:  low_bits = 3'b011;
      default: low_bits = 3'b111;
    endcase
    return |(offset & low_bits);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store strobe/data placement and load extraction/extension.
module mem_lane_align
  import common::*;
  import pipes::*;
(
  input  msize_t               size,
  input  logic                 mem_write,
  input  logic                 mem_unsigned,
  input  logic [2:0]           offset,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata,
  output logic [BUS_BYTES-1:0] strobe,
  output logic [XLEN-1:0]      wdata_lane,
  output logic [XLEN-1:0]      rdata_ext
);

  logic [5:0]      bit_shift;
  logic [XLEN-1:0] rdata_shifted;

  always_comb begin
    bit_shift     = {offset, 3'b000};
    // Mask bits shifted past the top lane fall off the 8-bit result.
    strobe        = mem_write ? (size_mask(size) << offset) : '0;
    wdata_lane    = wdata << bit_shift;
    rdata_shifted = rdata >> bit_shift;
    rdata_ext     = rdata_shifted;
    case (size)
      MSIZE1: rdata_ext = {{(XLEN-8){~mem_unsigned & rdata_shifted[7]}}, rdata_shifted[7:0]};
      MSIZE2: rdata_ext = {{(XLEN-16){~mem_unsigned & rdata_shifted[15]}}, rdata_shifted[15:0]};
      MSIZE4: rdata_ext = {{(XLEN-32){~mem_unsigned & rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: rdata_ext = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores on the data bus and stalls upstream until data_ok.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses skip the bus and report misalign.
module mem_access_stage
  import common::*;
  import pipes::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  execute_data_t        dataE,
  input  logic                 flush,
  output logic                 dreq_valid,
  output logic [XLEN-1:0]      dreq_addr,
  output msize_t               dreq_size,
  output logic [BUS_BYTES-1:0] dreq_strobe,
  output logic [XLEN-1:0]      dreq_data,
  input  logic                 dresp_addr_ok,
  input  logic                 dresp_data_ok,
  input  logic [XLEN-1:0]      dresp_data,
  output memory_data_t         dataM_next,
  output logic                 stall_out
);

  mem_state_t           state_q, state_d;
  logic                 squash_q, squash_d;
  logic [XLEN-1:0]      load_q, load_d;
  logic                 is_mem;
  logic                 bad_align;
  logic [BUS_BYTES-1:0] strobe;
  logic [XLEN-1:0]      wdata_lane;
  logic [XLEN-1:0]      rdata_ext;
  logic                 unused_addr_ok;

  assign unused_addr_ok = dresp_addr_ok;

  mem_lane_align u_lane_align (
    .size         (dataE.msize),
    .mem_write    (dataE.mem_write),
    .mem_unsigned (dataE.mem_unsigned),
    .offset       (dataE.addr[2:0]),
    .wdata        (dataE.wdata),
    .rdata        (dresp_data),
    .strobe       (strobe),
    .wdata_lane   (wdata_lane),
    .rdata_ext    (rdata_ext)
  );

  assign is_mem = dataE.valid & (dataE.mem_read | dataE.mem_write);

`ifdef MEM_MISALIGN_CHECK_EN
  assign bad_align = is_mem & misaligned(dataE.msize, dataE.addr[2:0]);
`else
  assign bad_align = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    squash_d           = squash_q;
    load_d             = load_q;
    dreq_valid         = 1'b0;
    stall_out          = 1'b0;
    dataM_next         = '0;
    dataM_next.rd      = dataE.rd;
    dataM_next.pc      = dataE.pc;
    dataM_next.wb_data = dataE.result;

    unique case (state_q)
      IDLE: begin
        if (is_mem && !bad_align) begin
          // Reset gates the combinational issue so the bus sees no request while held.
          if (!flush && reset) begin
            dreq_valid = 1'b1;
            stall_out  = 1'b1;
            if (dresp_data_ok) begin
              load_d  = rdata_ext;
              state_d = DONE;
            end else begin
              state_d = WAIT;
            end
          end
        end else begin
          dataM_next.valid = dataE.valid & ~flush;
`ifdef MEM_MISALIGN_CHECK_EN
          if (bad_align) begin
            dataM_next.wb_data  = dataE.addr;
            dataM_next.misalign = 1'b1;
          end
`endif
        end
      end

      WAIT: begin
        // The bus cannot be aborted; a flush only marks the result as dead.
        dreq_valid = 1'b1;
        stall_out  = 1'b1;
        squash_d   = squash_q | flush;
        if (dresp_data_ok) begin
          load_d  = rdata_ext;
          state_d = DONE;
        end
      end

      DONE: begin
        dataM_next.valid   = ~(squash_q | flush);
        dataM_next.wb_data = dataE.mem_read ? load_q : dataE.result;
        squash_d           = 1'b0;
        state_d            = IDLE;
      end

      default: begin
        state_d  = IDLE;
        squash_d = 1'b0;
      end
    endcase
  end

  assign dreq_addr   = dreq_valid ? dataE.addr : '0;
  assign dreq_size   = dreq_valid ? dataE.msize : MSIZE1;
  assign dreq_strobe = dreq_valid ? strobe : '0;
  assign dreq_data   = dreq_valid ? wdata_lane : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
      load_q   <= '0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      load_q   <= load_d;
    end
  end

endmodule
